// File: rtl/llc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : llc_req_arbiter
// Description : Three-channel (cpu/snoop/maintenance) request arbiter feeding
//               a single-outstanding LLC command port, with starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module llc_req_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic [3:0]            cpu_op,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  snp_valid,
    output logic                  snp_ready,
    input  logic [3:0]            snp_op,
    input  logic [ADDR_WIDTH-1:0] snp_addr,
    input  logic                  mnt_valid,
    output logic                  mnt_ready,
    input  logic [3:0]            mnt_op,
    output logic                  llc_valid,
    output logic [3:0]            llc_op,
    output logic [ADDR_WIDTH-1:0] llc_addr,
    input  logic                  llc_done,
    output logic [1:0]            grant_src,
    output logic                  drop_pulse,
    output logic [31:0]           issue_cnt,
    output logic [15:0]           drop_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [1:0]  c_SRC_NONE   = 2'd0;
    localparam logic [1:0]  c_SRC_CPU    = 2'd1;
    localparam logic [1:0]  c_SRC_SNP    = 2'd2;
    localparam logic [1:0]  c_SRC_MNT    = 2'd3;
    localparam logic [3:0]  c_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [15:0] c_DROP_SAT   = 16'hFFFF;

    state_t                r_state;
    logic                  r_llc_valid;
    logic [3:0]            r_llc_op;
    logic [ADDR_WIDTH-1:0] r_llc_addr;
    logic [1:0]            r_grant_src;
    logic                  r_drop_pulse;
    logic [31:0]           r_issue_cnt;
    logic [15:0]           r_drop_cnt;
    logic [3:0]            r_starve_cnt;

    logic                  w_idle;
    logic                  w_cpu_starved;
    logic                  w_win_cpu;
    logic                  w_win_snp;
    logic                  w_win_mnt;
    logic                  w_accept;
    logic [1:0]            w_sel_src;
    logic [3:0]            w_sel_op;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_legal;

    // Ready is gated by rst_n so no handshake can complete while in reset.
    assign w_idle        = (r_state == ST_IDLE) && rst_n;
    assign w_cpu_starved = (r_starve_cnt == c_STARVE_MAX) && cpu_valid;
    assign w_win_mnt     = mnt_valid;
    assign w_win_snp     = !mnt_valid && snp_valid && !w_cpu_starved;
    assign w_win_cpu     = !mnt_valid && cpu_valid && (!snp_valid || w_cpu_starved);

    assign mnt_ready = w_idle && w_win_mnt;
    assign snp_ready = w_idle && w_win_snp;
    assign cpu_ready = w_idle && w_win_cpu;
    assign w_accept  = mnt_ready || snp_ready || cpu_ready;

    always_comb begin
        w_sel_src   = c_SRC_NONE;
        w_sel_op    = 4'd0;
        w_sel_addr  = '0;
        w_sel_legal = 1'b0;
        if (w_win_mnt) begin
            w_sel_src   = c_SRC_MNT;
            w_sel_op    = mnt_op;
            w_sel_legal = (mnt_op == 4'd8) || (mnt_op == 4'd9);
        end else if (w_win_snp) begin
            w_sel_src   = c_SRC_SNP;
            w_sel_op    = snp_op;
            w_sel_addr  = snp_addr;
            w_sel_legal = (snp_op >= 4'd3) && (snp_op <= 4'd6);
        end else if (w_win_cpu) begin
            w_sel_src   = c_SRC_CPU;
            w_sel_op    = cpu_op;
            w_sel_addr  = cpu_addr;
            w_sel_legal = (cpu_op <= 4'd2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_llc_valid  <= 1'b0;
            r_llc_op     <= 4'd0;
            r_llc_addr   <= '0;
            r_grant_src  <= c_SRC_NONE;
            r_drop_pulse <= 1'b0;
            r_issue_cnt  <= 32'd0;
            r_drop_cnt   <= 16'd0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_drop_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_grant_src <= w_sel_src;
                        // mnt grants with a waiting cpu leave the starvation count untouched.
                        if ((w_sel_src == c_SRC_SNP) && cpu_valid) begin
                            if (r_starve_cnt < c_STARVE_MAX) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end else if ((w_sel_src == c_SRC_CPU) || !cpu_valid) begin
                            r_starve_cnt <= 4'd0;
                        end
                        if (w_sel_legal) begin
                            r_state     <= ST_BUSY;
                            r_llc_valid <= 1'b1;
                            r_llc_op    <= w_sel_op;
                            r_llc_addr  <= w_sel_addr;
                        end else begin
                            r_drop_pulse <= 1'b1;
                            if (r_drop_cnt != c_DROP_SAT) begin
                                r_drop_cnt <= r_drop_cnt + 16'd1;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (llc_done) begin
                        r_state     <= ST_IDLE;
                        r_llc_valid <= 1'b0;
                        r_issue_cnt <= r_issue_cnt + 32'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign llc_valid  = r_llc_valid;
    assign llc_op     = r_llc_op;
    assign llc_addr   = r_llc_addr;
    assign grant_src  = r_grant_src;
    assign drop_pulse = r_drop_pulse;
    assign issue_cnt  = r_issue_cnt;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_llc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_llc_req_arbiter
// Description : Scoreboard bench for llc_req_arbiter with a transaction-level
//               arbitration model driving expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_llc_req_arbiter;

    localparam int AW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_valid = 1'b0, cpu_ready;
    logic [3:0]    cpu_op = 4'd0;
    logic [AW-1:0] cpu_addr = '0;
    logic          snp_valid = 1'b0, snp_ready;
    logic [3:0]    snp_op = 4'd0;
    logic [AW-1:0] snp_addr = '0;
    logic          mnt_valid = 1'b0, mnt_ready;
    logic [3:0]    mnt_op = 4'd0;
    logic          llc_valid;
    logic [3:0]    llc_op;
    logic [AW-1:0] llc_addr;
    logic          llc_done = 1'b0;
    logic [1:0]    grant_src;
    logic          drop_pulse;
    logic [31:0]   issue_cnt;
    logic [15:0]   drop_cnt;

    llc_req_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .mnt_valid(mnt_valid), .mnt_ready(mnt_ready), .mnt_op(mnt_op),
        .llc_valid(llc_valid), .llc_op(llc_op), .llc_addr(llc_addr), .llc_done(llc_done),
        .grant_src(grant_src), .drop_pulse(drop_pulse),
        .issue_cnt(issue_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          drop;
        logic [1:0]  src;
        logic [3:0]  op;
        logic [31:0] addr;
    } exp_t;

    exp_t       sbq[$];
    logic [1:0] seen[$];
    int         checks = 0;
    int         failures = 0;

    // Transaction-level model state
    bit          m_busy = 0;
    int          m_busy_cyc = 0;
    int          m_starve = 0;
    int          m_issue = 0;
    int          m_drop = 0;
    int          done_lat = 0;
    bit          rand_mode = 0;
    bit          snp_auto = 0;
    bit          c_pend = 0, s_pend = 0, n_pend = 0;
    logic [3:0]  c_op_r = 0, s_op_r = 0, n_op_r = 0;
    logic [31:0] c_addr_r = 0, s_addr_r = 0;

    // Monitor observations
    bit          prev_v = 0;
    logic [3:0]  held_op;
    logic [31:0] held_addr;
    int          vlen = 0;
    int          last_vlen = 0;
    int          n_drop_pulses = 0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit legal_of(input int src, input logic [3:0] op);
        case (src)
            1: return op <= 4'd2;
            2: return (op >= 4'd3) && (op <= 4'd6);
            3: return (op == 4'd8) || (op == 4'd9);
            default: return 1'b0;
        endcase
    endfunction

    task automatic gen_requests();
        int r;
        if (!c_pend && ($urandom % 3 == 0)) begin
            r = $urandom % 8;
            c_pend = 1;
            c_op_r = (r < 6) ? 4'(r % 3) : ((r == 6) ? 4'd7 : 4'($urandom % 16));
            c_addr_r = $urandom;
        end
        if (!s_pend && ($urandom % 3 == 0)) begin
            r = $urandom % 8;
            s_pend = 1;
            s_op_r = (r < 6) ? 4'(3 + r % 4) : ((r == 6) ? 4'd7 : 4'($urandom % 16));
            s_addr_r = $urandom;
        end
        if (!n_pend && ($urandom % 8 == 0)) begin
            r = $urandom % 8;
            n_pend = 1;
            n_op_r = (r < 6) ? 4'(8 + r % 2) : ((r == 6) ? 4'd7 : 4'($urandom % 16));
        end
    endtask

    // One clock of stimulus plus the model's view of what the DUT must do.
    task automatic step();
        int          w;
        bit          legal;
        logic [3:0]  op;
        logic [31:0] addr;
        exp_t        e;
        @(negedge clk);
        if (rand_mode) gen_requests();
        cpu_valid = c_pend; cpu_op = c_op_r; cpu_addr = c_addr_r;
        snp_valid = s_pend; snp_op = s_op_r; snp_addr = s_addr_r;
        mnt_valid = n_pend; mnt_op = n_op_r;
        if (m_busy) llc_done = (m_busy_cyc >= done_lat);
        else        llc_done = 1'($urandom % 2);
        #1;
        w = 0;
        if (!m_busy) begin
            if (n_pend) w = 3;
            else if (s_pend && !(m_starve == SL && c_pend)) w = 2;
            else if (c_pend) w = 1;
        end
        check("ready", {61'd0, mnt_ready, snp_ready, cpu_ready},
              {61'd0, (w == 3), (w == 2), (w == 1)});
        if (m_busy) begin
            m_busy_cyc++;
            if (llc_done) begin
                m_busy = 0;
                m_issue++;
            end
        end else if (w != 0) begin
            op    = (w == 3) ? n_op_r : ((w == 2) ? s_op_r : c_op_r);
            addr  = (w == 3) ? 32'd0 : ((w == 2) ? s_addr_r : c_addr_r);
            legal = legal_of(w, op);
            if (w == 2 && c_pend) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            else if (w == 1 || !c_pend) m_starve = 0;
            e.drop = !legal; e.src = 2'(w); e.op = op; e.addr = addr;
            sbq.push_back(e);
            if (legal) begin
                m_busy = 1;
                m_busy_cyc = 0;
                if (rand_mode) done_lat = $urandom % 4;
            end else begin
                m_drop++;
            end
            if (w == 1) c_pend = 0;
            if (w == 2 && !snp_auto) s_pend = 0;
            if (w == 3) n_pend = 0;
        end
    endtask

    task automatic run_quiet(input int max);
        int n = 0;
        while ((m_busy || c_pend || s_pend || n_pend) && n < max) begin
            step();
            n++;
        end
        if (n >= max) check("quiet_timeout", 1, 0);
        step();
        step();
    endtask

    // Asynchronous reset mid-cycle; checks that outputs clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        cpu_valid = 1; cpu_op = 4'd0; snp_valid = 1; snp_op = 4'd3; mnt_valid = 1; mnt_op = 4'd8;
        #1;
        check("rst_ready", {61'd0, mnt_ready, snp_ready, cpu_ready}, 64'd0);
        check("rst_llc_valid", llc_valid, 0);
        check("rst_issue_cnt", issue_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_grant_src", grant_src, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        check("rst_llc_op_addr", {llc_op, llc_addr}, 0);
        cpu_valid = 0; snp_valid = 0; mnt_valid = 0; llc_done = 0;
        m_busy = 0; m_busy_cyc = 0; m_starve = 0; m_issue = 0; m_drop = 0;
        c_pend = 0; s_pend = 0; n_pend = 0; snp_auto = 0; rand_mode = 0;
        sbq.delete();
        seen.delete();
        n_drop_pulses = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_v = 0;
            vlen = 0;
        end else begin
            if (drop_pulse) begin
                n_drop_pulses++;
                if (sbq.size() == 0) check("sb_unexpected_drop", 1, 0);
                else begin
                    mon_e = sbq.pop_front();
                    check("drop_expected", {63'd0, mon_e.drop}, 1);
                    check("drop_src", grant_src, mon_e.src);
                end
                seen.push_back(grant_src);
            end
            if (llc_valid && !prev_v) begin
                if (sbq.size() == 0) check("sb_unexpected_issue", 1, 0);
                else begin
                    mon_e = sbq.pop_front();
                    check("issue_expected", {63'd0, mon_e.drop}, 0);
                    check("issue_src", grant_src, mon_e.src);
                    check("issue_op", llc_op, mon_e.op);
                    check("issue_addr", llc_addr, mon_e.addr);
                end
                seen.push_back(grant_src);
                held_op = llc_op;
                held_addr = llc_addr;
                vlen = 1;
            end else if (llc_valid) begin
                check("hold_cmd", {llc_op, llc_addr}, {held_op, held_addr});
                vlen++;
            end else if (prev_v) begin
                last_vlen = vlen;
            end
            prev_v = llc_valid;
        end
    end

    initial begin
        do_reset();

        // Single cpu command, done one cycle after valid
        c_pend = 1; c_op_r = 4'd0; c_addr_r = 32'h10019d94; done_lat = 1;
        run_quiet(50);
        check("t1_issue_cnt", issue_cnt, 1);
        check("t1_grant_src", grant_src, 1);
        check("t1_valid_len", last_vlen, 2);
        check("t1_seen", seen.size(), 1);

        // Illegal ops are accepted and dropped
        do_reset();
        c_pend = 1; c_op_r = 4'd7; c_addr_r = 32'h1234;
        run_quiet(50);
        s_pend = 1; s_op_r = 4'd2; s_addr_r = 32'h5678;
        run_quiet(50);
        check("t2_drop_cnt", drop_cnt, 2);
        check("t2_issue_cnt", issue_cnt, 0);
        check("t2_drop_pulses", n_drop_pulses, 2);
        check("t2_grant_src", grant_src, 2);

        // snp beats cpu
        do_reset();
        done_lat = 2;
        c_pend = 1; c_op_r = 4'd1; c_addr_r = 32'hA0;
        s_pend = 1; s_op_r = 4'd4; s_addr_r = 32'hB0;
        run_quiet(50);
        check("t3_order", {seen.size() > 0 ? seen[0] : 2'd0, seen.size() > 1 ? seen[1] : 2'd0}, {2'd2, 2'd1});

        // mnt beats everything
        seen.delete();
        n_pend = 1; n_op_r = 4'd9;
        c_pend = 1; c_op_r = 4'd2; c_addr_r = 32'hC0;
        s_pend = 1; s_op_r = 4'd6; s_addr_r = 32'hD0;
        run_quiet(50);
        check("t4_first_mnt", seen.size() > 0 ? seen[0] : 2'd0, 3);
        check("t4_count", seen.size(), 3);

        // Starvation guard
        do_reset();
        done_lat = 0;
        snp_auto = 1;
        s_pend = 1; s_op_r = 4'd5; s_addr_r = 32'hE0;
        c_pend = 1; c_op_r = 4'd2; c_addr_r = 32'hF0;
        for (int i = 0; i < 200 && seen.size() < 6; i++) step();
        snp_auto = 0;
        run_quiet(50);
        if (seen.size() >= 6)
            check("t5_starve_order", {seen[0], seen[1], seen[2], seen[3], seen[4], seen[5]},
                  {2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2});
        else
            check("t5_starve_count", seen.size(), 6);

        // Randomized traffic
        do_reset();
        rand_mode = 1;
        done_lat = 0;
        for (int i = 0; i < 3000; i++) step();
        rand_mode = 0;
        run_quiet(200);
        check("rnd_issue_cnt", issue_cnt, m_issue);
        check("rnd_drop_cnt", drop_cnt, m_drop);
        check("rnd_sb_empty", sbq.size(), 0);

        // Reset while busy abandons the command
        do_reset();
        c_pend = 1; c_op_r = 4'd1; c_addr_r = 32'h55AA; done_lat = 6;
        for (int i = 0; i < 20 && !(m_busy && m_busy_cyc >= 2); i++) step();
        check("t6_pre_busy", llc_valid, 1);
        do_reset();
        c_pend = 1; c_op_r = 4'd2; c_addr_r = 32'h77; done_lat = 0;
        run_quiet(50);
        check("t6_issue_after", issue_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/llc_req_arbiter.md
LLC_REQ_ARBITER -- requirements
Module: llc_req_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, 32, address width of all request channels and the LLC port.
REQ-002 Parameter STARVE_LIMIT, 4, consecutive snoop grants allowed while a CPU request waits (range 1-15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 cpu_valid, cpu_ready  input/output  1 each  processor-side request handshake; legal ops 0-2.
REQ-006 cpu_op, cpu_addr  input  4, ADDR_WIDTH  processor-side operation code and address.
REQ-007 snp_valid, snp_ready  input/output  1 each  snooped-bus request handshake; legal ops 3-6.
REQ-008 snp_op, snp_addr  input  4, ADDR_WIDTH  snoop operation code and address.
REQ-009 mnt_valid, mnt_ready  input/output  1 each  maintenance handshake; legal ops 8 (clear/reset) and 9 (print contents).
REQ-010 mnt_op  input  4  maintenance operation code; has no address.
REQ-011 llc_valid  output  1  command presented to the LLC.
REQ-012 llc_op, llc_addr  output  4, ADDR_WIDTH  command to the LLC.
REQ-013 llc_done  input  1  LLC completion pulse.
REQ-014 grant_src  output  2  source of the current or last command: 0 none, 1 cpu, 2 snp, 3 mnt.
REQ-015 drop_pulse  output  1  one-cycle pulse when an illegal op is accepted and discarded.
REQ-016 issue_cnt, drop_cnt  output  32, 16  issued-command count (wraps) and dropped-request count (saturates at 16'hFFFF).

Function
REQ-017 The FSM SHALL have two states: IDLE and BUSY.
REQ-018 In IDLE, exactly one *_ready SHALL be asserted, combinationally, for the arbitration winner; all *_ready SHALL be 0 in BUSY.
REQ-019 Priority SHALL be mnt > snp > cpu, except as given in REQ-020.
REQ-020 When starve_cnt equals STARVE_LIMIT and cpu_valid is 1, cpu SHALL win over snp; mnt still wins over both.
REQ-021 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each snp grant made while cpu_valid is 1.
REQ-022 starve_cnt SHALL clear on any cpu grant.
REQ-023 starve_cnt SHALL clear on any grant made while cpu_valid is 0.
REQ-024 A legal accepted request (valid & ready) SHALL register op and addr and move the FSM to BUSY on the next edge. mnt ops SHALL drive llc_addr = 0.
REQ-025 In BUSY, llc_valid SHALL be 1, and llc_op/llc_addr SHALL hold stable until llc_done is sampled 1.
REQ-026 When llc_done is sampled 1 in BUSY, the FSM SHALL return to IDLE, with llc_valid = 0 on the following cycle, and issue_cnt SHALL increment once.
REQ-027 llc_done SHALL be ignored in IDLE.
REQ-028 Minimum issue spacing SHALL be 2 cycles per command.
REQ-029 An illegal op SHALL still be accepted (ready asserted) so the source does not stall, but SHALL NOT be issued.
REQ-030 On accepting an illegal op, the FSM SHALL stay in IDLE, drop_pulse SHALL be 1 for the following cycle, and drop_cnt SHALL increment.
REQ-031 Illegal ops are: cpu_op not in {0,1,2}; snp_op not in {3,4,5,6}; mnt_op not in {8,9}. Op 7 SHALL be illegal on every channel.
REQ-032 grant_src SHALL update on every accepted request, including dropped ones, and SHALL hold its value in IDLE.
REQ-033 A request on a losing channel SHALL wait without loss; no internal buffering beyond the single registered command is required.

Reset
REQ-034 While rst_n = 0, the following SHALL hold immediately, regardless of clock: state IDLE; llc_valid 0; llc_op 0; llc_addr 0; grant_src 0; drop_pulse 0; issue_cnt 0; drop_cnt 0; starve_cnt 0.
REQ-035 While rst_n = 0, all *_ready SHALL be 0.
REQ-036 Reset asserted while in BUSY SHALL abandon the in-flight command with no completion counted.
REQ-037 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 cpu op 0, addr 32'h10019d94; llc_done 1 cycle after llc_valid -> llc_valid high 2 cycles with op 0 / that addr; issue_cnt = 1; grant_src = 1.
REQ-039 cpu op 1 and snp op 4 both valid in IDLE -> snp granted first (grant_src 2); cpu granted after that llc_done.
REQ-040 STARVE_LIMIT = 4, cpu_valid held, snp_valid held -> exactly 4 snp commands, then the cpu command, then snp resumes.
REQ-041 mnt op 9 concurrent with cpu and snp requests -> mnt issued first with llc_addr = 0.
REQ-042 cpu op 7, then snp op 2 -> both accepted, neither issued; 2 drop_pulses; drop_cnt = 2; issue_cnt = 0.
REQ-043 rst_n low for 1 cycle mid-BUSY -> llc_valid 0 immediately; counters 0; a new request after release is issued normally.
